// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the processor dmem port. Decodes each
// word address onto a local RAM, a memory-mapped transmit FIFO with status,
// or a free-running cycle counter. Load data is registered (1-cycle latency).
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h0000FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        io_valid,
  output logic [31:0] io_data,
  input  logic        io_ready,
  output logic        ovf_flag
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_TXDATA,
    TGT_STATUS,
    TGT_CYCLES,
    TGT_NONE
  } target_e;

  target_e            target;
  logic               storeEn;
  logic               pushReq;
  logic               pushOk;
  logic               popEn;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [31:0]        readMux;
  logic [31:0]        cycleCount;
  logic [CNT_W-1:0]   fifoCount;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [31:0]        ram      [RAM_WORDS];
  logic [31:0]        fifoMem  [FIFO_DEPTH];

  // Full 32-bit address decode onto one target; RAM range checked first.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    target = TGT_NONE;
    if (address_dmem < 32'(RAM_WORDS))          target = TGT_RAM;
    else if (address_dmem == IO_BASE)           target = TGT_TXDATA;
    else if (address_dmem == IO_BASE + 32'd1)   target = TGT_STATUS;
    else if (address_dmem == IO_BASE + 32'd2)   target = TGT_CYCLES;
  end

  // Stores in a reset cycle are discarded everywhere, including the RAM.
  assign storeEn   = wren & ~reset;
  assign fifoFull  = (fifoCount == FULL_CNT);
  assign fifoEmpty = (fifoCount == '0);
  assign popEn     = io_valid & io_ready;
  assign pushReq   = storeEn & (target == TGT_TXDATA);
  // A pop in the same cycle frees the slot the push needs.
  assign pushOk    = pushReq & (~fifoFull | popEn);

  assign io_valid  = ~fifoEmpty;
  assign io_data   = io_valid ? fifoMem[rdPtr] : '0;

  // RAM word write port.
  always_ff @(posedge clock) begin
    // NOTE: memory arrays carry no reset, so they map onto RAM macros; contents survive reset.
    if (storeEn && target == TGT_RAM) begin
      ram[address_dmem[RAM_AW-1:0]] <= data;
    end
  end

  // Load data selection from pre-edge state (gives read-before-write).
  always_comb begin
    readMux = '0;
    case (target)
      TGT_RAM:    readMux = ram[address_dmem[RAM_AW-1:0]];
      TGT_TXDATA: readMux = 32'(fifoCount);
      TGT_STATUS: readMux = {29'b0, ovf_flag, fifoFull, fifoEmpty};
      TGT_CYCLES: readMux = cycleCount;
      default:    readMux = '0;
    endcase
  end

  // Registered load data.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= only, so every register samples pre-edge values regardless of block order.
    if (reset) q_dmem <= '0;
    else       q_dmem <= readMux;
  end

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    if (pushOk) fifoMem[wrPtr] <= data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
      case ({pushOk, popEn})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Sticky overflow: set by a dropped push, cleared by any STATUS write.
  always_ff @(posedge clock) begin
    if (reset)                                    ovf_flag <= 1'b0;
    else if (storeEn && target == TGT_STATUS)     ovf_flag <= 1'b0;
    else if (pushReq && fifoFull && !popEn)       ovf_flag <= 1'b1;
  end

  // Free-running cycle counter; a CYCLES write wins over the increment.
  always_ff @(posedge clock) begin
    if (reset)                                    cycleCount <= '0;
    else if (storeEn && target == TGT_CYCLES)     cycleCount <= data;
    else                                          cycleCount <= cycleCount + 32'd1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps then random traffic, each edge
// checked against a queue/array model of the memory-mapped behaviour.
module tb_dmem_responder;

  localparam logic [31:0] IO_BASE = 32'h0000FFF0;
  localparam logic [31:0] A_TX    = IO_BASE;
  localparam logic [31:0] A_ST    = IO_BASE + 32'd1;
  localparam logic [31:0] A_CY    = IO_BASE + 32'd2;
  localparam logic [31:0] A_NONE  = 32'h1000_0000;
  localparam int          DEPTH   = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        io_valid;
  logic [31:0] io_data;
  logic        io_ready;
  logic        ovf_flag;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] mRam [int];
  logic [31:0] mFifo [$];
  logic        mOvf = 1'b0;
  logic [31:0] mCycles = '0;
  logic [31:0] mQ = '0;
  logic        mQKnown = 1'b1;

  dmem_responder #(.RAM_WORDS(4096), .FIFO_DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .io_valid(io_valid), .io_data(io_data),
    .io_ready(io_ready), .ovf_flag(ovf_flag)
  );

  always #5 clock = ~clock;

  task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Model of one rising edge: read value from pre-edge state, then updates.
  task automatic modelEdge(input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic rdy, input logic rst);
    bit popping;
    if (rst) begin
      mQ = '0; mQKnown = 1'b1; mFifo.delete(); mOvf = 1'b0; mCycles = '0;
      return;
    end
    mQKnown = 1'b1;
    if (a < 32'd4096) begin
      if (mRam.exists(int'(a))) mQ = mRam[int'(a)];
      else begin mQ = '0; mQKnown = 1'b0; end
    end else if (a == A_TX) mQ = 32'(mFifo.size());
    else if (a == A_ST)     mQ = {29'b0, mOvf, mFifo.size() == DEPTH, mFifo.size() == 0};
    else if (a == A_CY)     mQ = mCycles;
    else                    mQ = '0;

    popping = (mFifo.size() > 0) && rdy;
    if (we && a == A_TX) begin
      if (mFifo.size() < DEPTH || popping) begin
        if (popping) void'(mFifo.pop_front());
        mFifo.push_back(d);
        popping = 0;
      end else mOvf = 1'b1;
    end
    if (popping) void'(mFifo.pop_front());
    if (we && a == A_ST) mOvf = 1'b0;
    if (we && a < 32'd4096) mRam[int'(a)] = d;
    if (we && a == A_CY) mCycles = d;
    else                 mCycles = mCycles + 32'd1;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic rdy, input logic rst = 1'b0);
    address_dmem = a; data = d; wren = we; io_ready = rdy; reset = rst;
    @(posedge clock);
    modelEdge(a, d, we, rdy, rst);
    #1;
    if (mQKnown) checkOne("q_dmem", q_dmem, mQ);
    checkOne("io_valid", 32'(io_valid), 32'(mFifo.size() > 0));
    if (mFifo.size() > 0) checkOne("io_data", io_data, mFifo[0]);
    checkOne("ovf_flag", 32'(ovf_flag), 32'(mOvf));
  endtask

  initial begin
    logic [31:0] ra;
    int          pick;

    // Reset and idle
    step(A_NONE, 0, 0, 0, 1);
    step(A_NONE, 0, 0, 0, 1);
    checkOne("rst_q", q_dmem, 32'h0);
    checkOne("rst_io_data", io_data, 32'h0);
    for (int i = 0; i < 10; i++) step(A_NONE, 0, 0, 0);
    step(A_CY, 0, 0, 0);
    checkOne("cycles_after_idle", q_dmem, 32'd10);

    // RAM write/read and read-before-write
    step(32'd5, 32'hDEADBEEF, 1, 0);
    step(32'd5, 0, 0, 0);
    checkOne("ram_read", q_dmem, 32'hDEADBEEF);
    step(32'd5, 32'h1, 1, 0);
    checkOne("ram_rbw_old", q_dmem, 32'hDEADBEEF);
    step(32'd5, 0, 0, 0);
    checkOne("ram_rbw_new", q_dmem, 32'h1);

    // Overfill FIFO with consumer stalled
    for (int i = 1; i <= 9; i++) step(A_TX, 32'(i), 1, 0);
    step(A_ST, 0, 0, 0);
    checkOne("status_full_ovf", q_dmem, 32'h6);
    step(A_TX, 0, 0, 0);
    checkOne("txdata_count", q_dmem, 32'd8);
    for (int i = 1; i <= 8; i++) begin
      checkOne("drain_word", io_data, 32'(i));
      step(A_NONE, 0, 0, 1);
    end
    checkOne("drained_valid", 32'(io_valid), 32'd0);

    // STATUS write clears overflow
    step(A_ST, 32'h1234, 1, 0);
    checkOne("ovf_cleared", 32'(ovf_flag), 32'd0);

    // Full FIFO, simultaneous pop and push
    for (int i = 0; i < 8; i++) step(A_TX, 32'h10 + 32'(i), 1, 0);
    step(A_TX, 32'hA5, 1, 1);
    step(A_TX, 0, 0, 0);
    checkOne("count_after_pushpop", q_dmem, 32'd8);
    checkOne("no_ovf_pushpop", 32'(ovf_flag), 32'd0);
    for (int i = 1; i < 8; i++) begin
      checkOne("drain2_word", io_data, 32'h10 + 32'(i));
      step(A_NONE, 0, 0, 1);
    end
    checkOne("drain2_last", io_data, 32'hA5);
    step(A_NONE, 0, 0, 1);

    // Cycle counter load and wrap
    step(A_CY, 32'hFFFFFFFE, 1, 0);
    step(A_NONE, 0, 0, 0);
    step(A_CY, 0, 0, 0);
    checkOne("cycles_ffffffff", q_dmem, 32'hFFFFFFFF);
    step(A_CY, 0, 0, 0);
    checkOne("cycles_wrap", q_dmem, 32'h0);

    // Unmapped address
    step(IO_BASE + 32'd3, 32'h55, 1, 0);
    step(IO_BASE + 32'd3, 0, 0, 0);
    checkOne("unmapped_read", q_dmem, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1, 2: ra = 32'($urandom_range(0, 15));
        3, 4, 5: ra = A_TX;
        6:       ra = A_ST;
        7:       ra = A_CY;
        8:       ra = 32'd4095;
        default: ra = A_NONE + 32'($urandom_range(0, 3));
      endcase
      step(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end

    // Reset mid-burst
    step(32'd7, 32'h77, 1, 0);
    step(A_NONE, 0, 0, 1);
    while (io_valid) step(A_NONE, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(A_TX, 32'hC0 + 32'(i), 1, 0);
    checkOne("burst_valid", 32'(io_valid), 32'd1);
    step(32'd7, 32'h0BAD, 1, 0, 1);
    checkOne("rst_burst_valid", 32'(io_valid), 32'd0);
    checkOne("rst_burst_q", q_dmem, 32'h0);
    checkOne("rst_burst_ovf", 32'(ovf_flag), 32'd0);
    step(32'd7, 0, 0, 0);
    checkOne("ram_kept", q_dmem, 32'h77);
    step(A_TX, 0, 0, 0);
    checkOne("rst_count", q_dmem, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
